// File: rtl/mdio_frame_ctrl.sv
// mdio_frame_ctrl
//   Clause-22 MDIO management-frame sequencer. It emits one frame bit per MDC
//   cycle into the downstream MDIO bit-level data controller. The frame is the
//   preamble, ST, OP, PHYAD, REGAD, TA, DATA and a one-slot TAIL. For reads it
//   collects the 16 returned data bits.
// Ports
//   i_mdio_clk_mdc  MDC clock, rising edge
//   i_reset         synchronous active-high reset
//   i_start         frame request, honoured only when idle
//   i_op_read       1 = read (OP=10), 0 = write (OP=01), latched with i_start
//   i_phy_addr      PHY address, latched with i_start
//   i_reg_addr      register address, latched with i_start
//   i_wdata         write data, latched with i_start
//   i_r_data_bit    registered sampled bus bit from the data controller
//   o_w_data_bit    bit to drive while o_mdio_io = 0
//   o_mdio_io       0 = drive o_w_data_bit, 1 = release bus / sample
//   o_busy          frame in progress
//   o_done          one-cycle pulse at frame end
//   o_rdata         last completed read data
module mdio_frame_ctrl #(
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        i_mdio_clk_mdc,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_op_read,
   input  logic [4:0]  i_phy_addr,
   input  logic [4:0]  i_reg_addr,
   input  logic [15:0] i_wdata,
   input  logic        i_r_data_bit,
   output logic        o_w_data_bit,
   output logic        o_mdio_io,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_rdata
);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_TAIL
   } state_t;

   localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        op_rd_q, op_rd_d;
   logic [4:0]  phy_q, phy_d;
   logic [4:0]  reg_q, reg_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] shift_q, shift_d;
   logic [15:0] rdata_q, rdata_d;
   logic        w_q, w_d;
   logic        io_q, io_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] hdr;
   logic        capture;

   // cnt counts preamble slots in PRE. From ST onwards it counts the frame slot
   // relative to ST (0..32), so 6 bits never wrap. The outputs are registered
   // from the next-state values, so each slot's bit appears at the edge that
   // opens that slot.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_rd_d = op_rd_q;
      phy_d   = phy_q;
      reg_d   = reg_q;
      wdata_d = wdata_q;
      shift_d = shift_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;

      // i_r_data_bit lags the bus by one slot, so capture runs one slot late
      // (ST-relative 17..32) and the last shift merges into o_rdata at TAIL end.
      capture = op_rd_q && ((state_q == S_DATA && cnt_q >= 6'd17) || state_q == S_TAIL);
      if (capture)
         shift_d = {shift_q[14:0], i_r_data_bit};

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               op_rd_d = i_op_read;
               phy_d   = i_phy_addr;
               reg_d   = i_reg_addr;
               wdata_d = i_wdata;
               cnt_d   = '0;
               state_d = (PREAMBLE_LEN == 0) ? S_ST : S_PRE;
            end
         end
         S_PRE: begin
            if (cnt_q == PRE_LAST) begin
               state_d = S_ST;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         S_TAIL: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            if (op_rd_q)
               rdata_d = shift_d;
         end
         default: begin
            cnt_d = cnt_q + 6'd1;
            case (cnt_q)
               6'd1:    state_d = S_OP;
               6'd3:    state_d = S_PHYAD;
               6'd8:    state_d = S_REGAD;
               6'd13:   state_d = S_TA;
               6'd15:   state_d = S_DATA;
               6'd31:   state_d = S_TAIL;
               default: ;
            endcase
         end
      endcase

      // ST, OP, PHYAD, REGAD and write-TA form one 16-bit word. Slot k
      // (0..15) maps to bit 15-k, which equals ~k[3:0]. The same index
      // selects wdata bit 15..0 for DATA slots 16..31.
      hdr    = {2'b01, (op_rd_d ? 2'b10 : 2'b01), phy_d, reg_d, 2'b10};
      busy_d = (state_d != S_IDLE);
      w_d    = 1'b1;
      io_d   = 1'b1;
      case (state_d)
         S_PRE: io_d = 1'b0;
         S_ST, S_OP, S_PHYAD, S_REGAD: begin
            io_d = 1'b0;
            w_d  = hdr[~cnt_d[3:0]];
         end
         S_TA: begin
            if (!op_rd_d) begin
               io_d = 1'b0;
               w_d  = hdr[~cnt_d[3:0]];
            end
         end
         S_DATA: begin
            if (!op_rd_d) begin
               io_d = 1'b0;
               w_d  = wdata_d[~cnt_d[3:0]];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_mdio_clk_mdc) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_rd_q <= 1'b0;
         phy_q   <= '0;
         reg_q   <= '0;
         wdata_q <= '0;
         shift_q <= '0;
         rdata_q <= '0;
         w_q     <= 1'b1;
         io_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_rd_q <= op_rd_d;
         phy_q   <= phy_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
         shift_q <= shift_d;
         rdata_q <= rdata_d;
         w_q     <= w_d;
         io_q    <= io_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_w_data_bit = w_q;
   assign o_mdio_io    = io_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_rdata      = rdata_q;

endmodule

// File: tb/tb_mdio_frame_ctrl.sv
// tb_mdio_frame_ctrl
//   Two instances: index 0 has PREAMBLE_LEN=32, index 1 has PREAMBLE_LEN=0.
//   Each instance has a PHY responder and a one-cycle data-controller register
//   model feeding i_r_data_bit.
module tb_mdio_frame_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [2];
   logic        start   [2];
   logic        op_rd   [2];
   logic [4:0]  phy     [2];
   logic [4:0]  regad   [2];
   logic [15:0] wdata   [2];
   logic        r_bit   [2];
   logic        phy_val [2];
   logic        o_w     [2];
   logic        o_io    [2];
   logic        o_busy  [2];
   logic        o_done  [2];
   logic [15:0] o_rdata [2];

   int checks = 0;
   int failures = 0;
   logic [15:0] last_rd [2];

   typedef struct {
      int        d;
      bit        rd;
      bit [4:0]  phy;
      bit [4:0]  regad;
      bit [15:0] wdata;
      bit [15:0] phy_data;
      bit [15:0] exp_rdata;
   } vec_t;

   bit e_io[$];
   bit e_w[$];

   mdio_frame_ctrl #(.PREAMBLE_LEN(32)) u_p32 (
      .i_mdio_clk_mdc(clk), .i_reset(rst[0]), .i_start(start[0]), .i_op_read(op_rd[0]),
      .i_phy_addr(phy[0]), .i_reg_addr(regad[0]), .i_wdata(wdata[0]), .i_r_data_bit(r_bit[0]),
      .o_w_data_bit(o_w[0]), .o_mdio_io(o_io[0]), .o_busy(o_busy[0]), .o_done(o_done[0]),
      .o_rdata(o_rdata[0]));

   mdio_frame_ctrl #(.PREAMBLE_LEN(0)) u_p0 (
      .i_mdio_clk_mdc(clk), .i_reset(rst[1]), .i_start(start[1]), .i_op_read(op_rd[1]),
      .i_phy_addr(phy[1]), .i_reg_addr(regad[1]), .i_wdata(wdata[1]), .i_r_data_bit(r_bit[1]),
      .o_w_data_bit(o_w[1]), .o_mdio_io(o_io[1]), .o_busy(o_busy[1]), .o_done(o_done[1]),
      .o_rdata(o_rdata[1]));

   // Data-controller register: during slot s+1 it presents the bus value of slot s.
   always @(posedge clk) begin
      r_bit[0] <= o_io[0] ? phy_val[0] : o_w[0];
      r_bit[1] <= o_io[1] ? phy_val[1] : o_w[1];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      op_rd[v.d] = v.rd;
      phy[v.d]   = v.phy;
      regad[v.d] = v.regad;
      wdata[v.d] = v.wdata;
   endtask

   task automatic push_slot(input bit io, input bit w);
      e_io.push_back(io);
      e_w.push_back(w);
   endtask

   // Expected bus activity per slot, written field by field from the frame format.
   task automatic build_frame(input vec_t v, input int p);
      e_io.delete();
      e_w.delete();
      for (int i = 0; i < p; i++) push_slot(1'b0, 1'b1);
      push_slot(1'b0, 1'b0); push_slot(1'b0, 1'b1);
      if (v.rd) begin push_slot(1'b0, 1'b1); push_slot(1'b0, 1'b0); end
      else      begin push_slot(1'b0, 1'b0); push_slot(1'b0, 1'b1); end
      for (int i = 4; i >= 0; i--) push_slot(1'b0, v.phy[i]);
      for (int i = 4; i >= 0; i--) push_slot(1'b0, v.regad[i]);
      if (v.rd) begin push_slot(1'b1, 1'b1); push_slot(1'b1, 1'b1); end
      else      begin push_slot(1'b0, 1'b1); push_slot(1'b0, 1'b0); end
      for (int i = 15; i >= 0; i--) begin
         if (v.rd) push_slot(1'b1, 1'b1);
         else      push_slot(1'b0, v.wdata[i]);
      end
      push_slot(1'b1, 1'b1);
   endtask

   // PHY side of the bus: Z (pulled up) then 0 in TA, then the data MSB first.
   function automatic bit phy_drive(input vec_t v, input int p, input int s);
      if (!v.rd) return 1'b1;
      if (s == p + 15) return 1'b0;
      if (s >= p + 16 && s <= p + 31) return v.phy_data[p + 31 - s];
      return 1'b1;
   endfunction

   task automatic run_frame(input vec_t v, input int glitch_slot, input int rst_slot,
                            input bit pre_started, input bit chain, input vec_t nv);
      int d;
      int p;
      int n;
      d = v.d;
      p = (d == 0) ? 32 : 0;
      n = p + 33;
      build_frame(v, p);
      if (!pre_started) begin
         @(negedge clk);
         drive(v);
         start[d] = 1'b1;
         @(posedge clk);
         #1 start[d] = 1'b0;
      end
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         phy_val[d] = phy_drive(v, p, s);
         check($sformatf("d%0d slot%0d io_w_busy_done", d, s),
               {28'd0, o_io[d], o_w[d], o_busy[d], o_done[d]},
               {28'd0, e_io[s], e_w[s], 1'b1, 1'b0});
         if (s == glitch_slot) begin
            start[d] = 1'b1;
            op_rd[d] = ~v.rd;
            phy[d]   = ~v.phy;
            regad[d] = ~v.regad;
            wdata[d] = ~v.wdata;
         end
         if (s == glitch_slot + 1) start[d] = 1'b0;
         if (chain && s == n - 1) begin
            drive(nv);
            start[d] = 1'b1;
         end
         if (s == rst_slot) begin
            rst[d] = 1'b1;
            @(posedge clk);
            #1 rst[d] = 1'b0;
            phy_val[d] = 1'b1;
            @(negedge clk);
            check($sformatf("d%0d reset io_w_busy_done", d),
                  {28'd0, o_io[d], o_w[d], o_busy[d], o_done[d]}, 32'hC);
            check($sformatf("d%0d reset rdata", d), {16'd0, o_rdata[d]}, 32'd0);
            last_rd[d] = 16'h0;
            repeat (3) begin
               @(negedge clk);
               check($sformatf("d%0d post-reset busy_done", d),
                     {30'd0, o_busy[d], o_done[d]}, 32'd0);
            end
            return;
         end
      end
      @(negedge clk);
      phy_val[d] = 1'b1;
      check($sformatf("d%0d done io_w_busy_done", d),
            {28'd0, o_io[d], o_w[d], o_busy[d], o_done[d]}, 32'hD);
      check($sformatf("d%0d rdata", d), {16'd0, o_rdata[d]}, {16'd0, v.exp_rdata});
      if (v.rd) last_rd[d] = v.phy_data;
      if (chain) begin
         @(posedge clk);
         #1 start[d] = 1'b0;
      end else begin
         @(negedge clk);
         check($sformatf("d%0d after-done busy_done", d),
               {30'd0, o_busy[d], o_done[d]}, 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL timeout: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      vec_t tbl [8];
      vec_t none;
      vec_t a;
      vec_t b;
      none = '{default: 0};

      tbl[0] = '{0, 1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 16'h0000};
      tbl[1] = '{0, 1'b1, 5'h03, 5'h02, 16'h0000, 16'h0141, 16'h0141};
      tbl[2] = '{1, 1'b0, 5'h1F, 5'h15, 16'hA5A5, 16'h0000, 16'h0000};
      tbl[3] = '{1, 1'b1, 5'h00, 5'h1F, 16'h0000, 16'h8001, 16'h8001};
      tbl[4] = '{0, 1'b0, 5'h10, 5'h01, 16'hFFFF, 16'h0000, 16'h0141};
      tbl[5] = '{0, 1'b1, 5'h1A, 5'h05, 16'h0000, 16'h0000, 16'h0000};
      tbl[6] = '{0, 1'b1, 5'h05, 5'h1A, 16'h0000, 16'hFFFF, 16'hFFFF};
      tbl[7] = '{1, 1'b0, 5'h0A, 5'h15, 16'h0000, 16'h0000, 16'h8001};

      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0; op_rd[i] = 1'b0; phy[i] = '0;
         regad[i] = '0; wdata[i] = '0; phy_val[i] = 1'b1; last_rd[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("d%0d reset-state io_w_busy_done", i),
               {28'd0, o_io[i], o_w[i], o_busy[i], o_done[i]}, 32'hC);
         check($sformatf("d%0d reset-state rdata", i), {16'd0, o_rdata[i]}, 32'd0);
      end
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      for (int i = 0; i < 8; i++) run_frame(tbl[i], -1, -1, 1'b0, 1'b0, none);

      // Start request mid-frame with different fields must be ignored.
      a = '{0, 1'b0, 5'h07, 5'h09, 16'hBEEF, 16'h0000, 16'hFFFF};
      run_frame(a, 10, -1, 1'b0, 1'b0, none);

      // Reset during a read, then a normal read.
      a = '{0, 1'b1, 5'h03, 5'h02, 16'h0000, 16'h1234, 16'h0000};
      run_frame(a, -1, 40, 1'b0, 1'b0, none);
      a = '{0, 1'b1, 5'h03, 5'h02, 16'h0000, 16'h5A3C, 16'h5A3C};
      run_frame(a, -1, -1, 1'b0, 1'b0, none);

      // Back-to-back frames with i_start held across o_done.
      a = '{0, 1'b0, 5'h02, 5'h03, 16'h0F0F, 16'h0000, 16'h5A3C};
      b = '{0, 1'b1, 5'h04, 5'h05, 16'h0000, 16'hC3C3, 16'hC3C3};
      run_frame(a, -1, -1, 1'b0, 1'b1, b);
      run_frame(b, -1, -1, 1'b1, 1'b0, none);
      a = '{1, 1'b0, 5'h11, 5'h12, 16'h1234, 16'h0000, 16'h8001};
      b = '{1, 1'b1, 5'h13, 5'h14, 16'h0000, 16'h6E6E, 16'h6E6E};
      run_frame(a, -1, -1, 1'b0, 1'b1, b);
      run_frame(b, -1, -1, 1'b1, 1'b0, none);

      // Random frames against the model.
      for (int unsigned k = 0; k < 20; k++) begin
         a.d        = int'(k % 2);
         a.rd       = 1'($urandom_range(0, 1));
         a.phy      = 5'($urandom);
         a.regad    = 5'($urandom);
         a.wdata    = 16'($urandom);
         a.phy_data = 16'($urandom);
         a.exp_rdata = a.rd ? a.phy_data : last_rd[a.d];
         run_frame(a, -1, -1, 1'b0, 1'b0, none);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
